// File: rtl/bus_rx8.sv
// bus_rx8: receiver for the shared 8-bit tri-state data bus.
// Each accepted byte is stored in a small FIFO together with the source ID
// that drove it. The FIFO presents its head first-word-fall-through on a
// valid/ready port. Sticky flags record bytes that had to be dropped.
module bus_rx8 #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          c,
  input  logic          r,
  input  logic [7:0]    bus_d,
  input  logic          bus_e,
  input  logic [2:0]    bus_src,
  output logic          bus_rdy,
  output logic [7:0]    out_d,
  output logic [2:0]    out_src,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          err,
  input  logic          clr
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic          src_ok;
  logic          wr_en;
  logic          rd_en;
  logic [10:0]   head;

  // Read-side view of every storage entry, {src, data} per slot.
  logic [DEPTH-1:0][10:0] entry_rd;

  // Handshake qualifiers: ready depends only on the fill level, never on out_rdy.
  always_comb begin
    src_ok  = (bus_src != 3'd0);
    bus_rdy = (count_q != FULL_CNT);
    out_vld = (count_q != '0);
    wr_en   = bus_e & bus_rdy & src_ok;
    rd_en   = out_vld & out_rdy;
  end

  // Next-state for pointers, fill level and sticky flags (set wins over clear).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q & ~clr) | (bus_e & ~bus_rdy);
    err_d = (err_q & ~clr) | (bus_e & ~src_ok);
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge c) begin
    if (!r) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // One storage slot per FIFO entry; contents need no reset because the
  // fill level alone decides whether a slot is visible.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [10:0] entry_q, entry_d;
    logic        hit;

    // Load the slot when the write pointer selects it.
    always_comb begin
      hit     = wr_en & r & (wr_ptr_q == AW'(gi));
      entry_d = hit ? {bus_src, bus_d} : entry_q;
    end

    // Slot register.
    always_ff @(posedge c) begin
      entry_q <= entry_d;
    end

    assign entry_rd[gi] = entry_q;
  end

  // Head presentation; zeroed while empty so stale bytes never leak out.
  always_comb begin
    head    = entry_rd[rd_ptr_q];
    out_d   = out_vld ? head[7:0]  : 8'd0;
    out_src = out_vld ? head[10:8] : 3'd0;
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bus_rx8.sv
// tb_bus_rx8: directed scenarios plus randomized traffic for bus_rx8,
// checked against a queue-based reference of the receive FIFO.
module tb_bus_rx8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          c = 1'b0;
  logic          r;
  logic [7:0]    bus_d;
  logic          bus_e;
  logic [2:0]    bus_src;
  logic          bus_rdy;
  logic [7:0]    out_d;
  logic [2:0]    out_src;
  logic          out_vld;
  logic          out_rdy;
  logic [AW:0]   count;
  logic          ovf;
  logic          err;
  logic          clr;

  int checks   = 0;
  int failures = 0;

  // Reference: ordered list of {src, data} held, plus the two sticky flags.
  logic [10:0] mq[$];
  bit          m_ovf;
  bit          m_err;

  bus_rx8 #(.DEPTH(DEPTH), .AW(AW)) dut (
    .c(c), .r(r), .bus_d(bus_d), .bus_e(bus_e), .bus_src(bus_src),
    .bus_rdy(bus_rdy), .out_d(out_d), .out_src(out_src), .out_vld(out_vld),
    .out_rdy(out_rdy), .count(count), .ovf(ovf), .err(err), .clr(clr)
  );

  always #5 c = ~c;

  // Apply one cycle of inputs (called just after a falling edge), advance the
  // reference by the receiver's rules, and return at the next falling edge.
  task automatic cycle(input bit rst_n, input bit e, input logic [2:0] src,
                       input logic [7:0] d, input bit rdy, input bit cl);
    bit full;
    bit wr;
    bit rd;
    r       = rst_n;
    bus_e   = e;
    bus_src = src;
    bus_d   = e ? d : 8'h00;
    out_rdy = rdy;
    clr     = cl;
    full = (mq.size() == DEPTH);
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      wr = e && !full && (src != 3'd0);
      rd = (mq.size() != 0) && rdy;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({src, d});
      m_ovf = (m_ovf && !cl) || (e && full);
      m_err = (m_err && !cl) || (e && (src == 3'd0));
    end
    @(posedge c);
    @(negedge c);
    $display("txn r=%0b e=%0b src=%0d d=%02h rdy=%0b clr=%0b -> cnt=%0d vld=%0b head=%0d/%02h ovf=%0b err=%0b",
             rst_n, e, src, d, rdy, cl, count, out_vld, out_src, out_d, ovf, err);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd2, 8'h77, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    checks += 6;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b want=0", out_vld); end
    if (out_d !== 8'h00) begin failures++; $display("FAIL reset_d got=%02h want=00", out_d); end
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    if (bus_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%0b want=1", bus_rdy); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err); end
  endtask

  task automatic test_order();
    cycle(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd7, 8'h5A, 1'b0, 1'b0);
    checks += 3;
    if (count !== 3'd2) begin failures++; $display("FAIL order_count got=%0d want=2", count); end
    if (out_d !== 8'hA5) begin failures++; $display("FAIL order_head1_d got=%02h want=a5", out_d); end
    if (out_src !== 3'd3) begin failures++; $display("FAIL order_head1_src got=%0d want=3", out_src); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    checks += 3;
    if (out_d !== 8'h5A) begin failures++; $display("FAIL order_head2_d got=%02h want=5a", out_d); end
    if (out_src !== 3'd7) begin failures++; $display("FAIL order_head2_src got=%0d want=7", out_src); end
    if (count !== 3'd1) begin failures++; $display("FAIL order_count1 got=%0d want=1", count); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    checks += 3;
    if (count !== 3'd0) begin failures++; $display("FAIL order_count0 got=%0d want=0", count); end
    if (out_vld !== 1'b0) begin failures++; $display("FAIL order_vld got=%0b want=0", out_vld); end
    if (out_src !== 3'd0) begin failures++; $display("FAIL order_empty_src got=%0d want=0", out_src); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, 3'd2, 8'(i), 1'b0, 1'b0);
      if (i == 4) begin
        checks++;
        if (bus_rdy !== 1'b0) begin failures++; $display("FAIL ovf_rdy_full got=%0b want=0", bus_rdy); end
      end
    end
    checks += 2;
    if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d want=4", count); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b want=1", ovf); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_d !== 8'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%02h want=%02h", i, out_d, 8'(i)); end
      cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    end
    checks += 2;
    if (count !== 3'd0) begin failures++; $display("FAIL ovf_drained got=%0d want=0", count); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b want=1", ovf); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0b want=0", ovf); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 3'd4, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd5, 8'hEE, 1'b1, 1'b0);
    checks += 3;
    if (count !== 3'd3) begin failures++; $display("FAIL fullrw_count got=%0d want=3", count); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL fullrw_ovf got=%0b want=1", ovf); end
    if (out_d !== 8'h11) begin failures++; $display("FAIL fullrw_head got=%02h want=11", out_d); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (out_d !== 8'h13) begin failures++; $display("FAIL fullrw_last got=%02h want=13", out_d); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    checks += 2;
    if (count !== 3'd0) begin failures++; $display("FAIL fullrw_drained got=%0d want=0", count); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL fullrw_clr got=%0b want=0", ovf); end
  endtask

  task automatic test_src0();
    cycle(1'b1, 1'b1, 3'd1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0);
    checks += 3;
    if (count !== 3'd1) begin failures++; $display("FAIL src0_count got=%0d want=1", count); end
    if (err !== 1'b1) begin failures++; $display("FAIL src0_err got=%0b want=1", err); end
    if (out_d !== 8'h21) begin failures++; $display("FAIL src0_head got=%02h want=21", out_d); end
    cycle(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b1);
    checks += 2;
    if (err !== 1'b1) begin failures++; $display("FAIL src0_set_wins got=%0b want=1", err); end
    if (count !== 3'd1) begin failures++; $display("FAIL src0_count2 got=%0d want=1", count); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    checks += 2;
    if (err !== 1'b0) begin failures++; $display("FAIL src0_clr got=%0b want=0", err); end
    if (count !== 3'd0) begin failures++; $display("FAIL src0_drained got=%0d want=0", count); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 3'((i % 7) + 1), 8'h30 + 8'(i), 1'b1, 1'b0);
      checks += 3;
      if (out_d !== 8'h30 + 8'(i)) begin failures++; $display("FAIL stream_d%0d got=%02h want=%02h", i, out_d, 8'h30 + 8'(i)); end
      if (out_src !== 3'((i % 7) + 1)) begin failures++; $display("FAIL stream_src%0d got=%0d want=%0d", i, out_src, (i % 7) + 1); end
      if (count !== 3'd1) begin failures++; $display("FAIL stream_count%0d got=%0d want=1", i, count); end
    end
    cycle(1'b1, 1'b1, 3'd6, 8'h99, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd6, 8'h9A, 1'b1, 1'b0);
    checks += 3;
    if (count !== 3'd0) begin failures++; $display("FAIL stream_rst_count got=%0d want=0", count); end
    if (out_vld !== 1'b0) begin failures++; $display("FAIL stream_rst_vld got=%0b want=0", out_vld); end
    if (bus_rdy !== 1'b1) begin failures++; $display("FAIL stream_rst_rdy got=%0b want=1", bus_rdy); end
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    logic [2:0] exp_s;
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0));
      exp_d = (mq.size() != 0) ? mq[0][7:0]  : 8'h00;
      exp_s = (mq.size() != 0) ? mq[0][10:8] : 3'd0;
      checks += 7;
      if (count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, mq.size()); end
      if (out_vld !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_vld n=%0d got=%0b want=%0b", n, out_vld, mq.size() != 0); end
      if (out_d !== exp_d) begin failures++; $display("FAIL rnd_d n=%0d got=%02h want=%02h", n, out_d, exp_d); end
      if (out_src !== exp_s) begin failures++; $display("FAIL rnd_src n=%0d got=%0d want=%0d", n, out_src, exp_s); end
      if (bus_rdy !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rnd_rdy n=%0d got=%0b want=%0b", n, bus_rdy, mq.size() != DEPTH); end
      if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%0b want=%0b", n, ovf, m_ovf); end
      if (err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%0b want=%0b", n, err, m_err); end
    end
  endtask

  initial begin
    r       = 1'b0;
    bus_e   = 1'b0;
    bus_src = 3'd0;
    bus_d   = 8'h00;
    out_rdy = 1'b0;
    clr     = 1'b0;
    @(negedge c);
    test_reset();
    test_order();
    test_overflow();
    test_full_rw();
    test_src0();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
